// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : main_control_fsm
//  Purpose  : Multicycle MIPS main control unit. Sequences
//             FETCH/DECODE/EXECUTE/MEM/WB for each instruction from the IR
//             opcode and drives the datapath muxes, the register-file and
//             memory enables, and the 2-bit sig_ALUop code consumed by the
//             ALU control decoder.
//  Build    : CTRL_ILLEGAL_TRAP_EN defined   -> unknown opcodes enter a
//             sticky TRAP state (illegal_op=1) that only reset leaves.
//             CTRL_ILLEGAL_TRAP_EN undefined -> unknown opcodes retire as a
//             NOP and illegal_op is tied 0.
//  Ports    : clk, rst_n (sync, active-low), opcode[OP_W], mem_ready
//             -> pc_write, pc_write_cond, iord, mem_read, mem_write,
//                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
//                alu_src_b[2], pc_source[2], sig_ALUop[2], instr_done,
//                illegal_op
//  Revision : 1.0 - initial release
// ============================================================================
module main_control_fsm #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_source,
  output logic [1:0]      sig_ALUop,
  output logic            instr_done,
  output logic            illegal_op
);

  localparam logic [OP_W-1:0] c_OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] c_OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] c_OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] c_OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] c_OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] c_OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] c_OP_J     = OP_W'(6'b000010);

  typedef enum logic [STATE_W-1:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX,
    RTYPE_WB, BEQ_EX, ADDI_EX, ANDI_EX, IMM_WB, JUMP, TRAP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = IDLE;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    sig_ALUop     = 2'b00;
    instr_done    = 1'b0;
    case (r_state)
      IDLE: w_state_next = FETCH;
      FETCH: begin
        // PC+4 is computed alongside the instruction read; PC and IR only
        // load in the cycle the memory actually returns data.
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        sig_ALUop    = 2'b11;
        ir_write     = mem_ready;
        pc_write     = mem_ready;
        w_state_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        sig_ALUop = 2'b11;
        if (opcode == c_OP_RTYPE)                         w_state_next = RTYPE_EX;
        else if (opcode == c_OP_LW || opcode == c_OP_SW)  w_state_next = MEMADR;
        else if (opcode == c_OP_BEQ)                      w_state_next = BEQ_EX;
        else if (opcode == c_OP_ADDI)                     w_state_next = ADDI_EX;
        else if (opcode == c_OP_ANDI)                     w_state_next = ANDI_EX;
        else if (opcode == c_OP_J)                        w_state_next = JUMP;
        else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_state_next = TRAP;
`else
          instr_done   = 1'b1;
          w_state_next = FETCH;
`endif
        end
      end
      MEMADR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        sig_ALUop    = 2'b11;
        w_state_next = (opcode == c_OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read     = 1'b1;
        iord         = 1'b1;
        w_state_next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        instr_done   = 1'b1;
        w_state_next = FETCH;
      end
      MEMWR: begin
        mem_write    = 1'b1;
        iord         = 1'b1;
        instr_done   = mem_ready;
        w_state_next = mem_ready ? FETCH : MEMWR;
      end
      RTYPE_EX: begin
        alu_src_a    = 1'b1;
        w_state_next = RTYPE_WB;
      end
      RTYPE_WB: begin
        reg_write    = 1'b1;
        reg_dst      = 1'b1;
        instr_done   = 1'b1;
        w_state_next = FETCH;
      end
      BEQ_EX: begin
        alu_src_a     = 1'b1;
        sig_ALUop     = 2'b10;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        w_state_next  = FETCH;
      end
      ADDI_EX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        sig_ALUop    = 2'b11;
        w_state_next = IMM_WB;
      end
      ANDI_EX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        sig_ALUop    = 2'b01;
        w_state_next = IMM_WB;
      end
      IMM_WB: begin
        reg_write    = 1'b1;
        instr_done   = 1'b1;
        w_state_next = FETCH;
      end
      JUMP: begin
        pc_write     = 1'b1;
        pc_source    = 2'b10;
        instr_done   = 1'b1;
        w_state_next = FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP: w_state_next = TRAP;
`endif
      default: w_state_next = IDLE;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal_op;

  // Set on the edge that enters TRAP so the flag is visible for the whole
  // time the FSM sits there; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)                  r_illegal_op <= 1'b0;
    else if (w_state_next == TRAP) r_illegal_op <= 1'b1;
  end

  assign illegal_op = r_illegal_op;
`else
  assign illegal_op = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_control_fsm
//  Purpose  : Self-checking bench for main_control_fsm. Each driven cycle
//             pushes the expected output word to a scoreboard queue; the
//             monitor pops and compares it half a cycle later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source, sig_ALUop;

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .sig_ALUop(sig_ALUop), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  wire [17:0] w_obs = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                       alu_src_b, pc_source, sig_ALUop, instr_done, illegal_op};

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Field order matches w_obs.
  function automatic logic [17:0] ov(input logic pcw, pcc, io, mr, mw, irw,
                                     m2r, rd, rw, sa, input logic [1:0] sbv,
                                     input logic [1:0] ps, aop,
                                     input logic done, ill);
    return {pcw, pcc, io, mr, mw, irw, m2r, rd, rw, sa, sbv, ps, aop, done, ill};
  endfunction

  logic [17:0] E_IDLE, E_FETCH_W, E_FETCH_R, E_DECODE, E_DECODE_NOP, E_MEMADR;
  logic [17:0] E_MEMRD, E_MEMWB, E_MEMWR_W, E_MEMWR_R, E_RTYPE_EX, E_RTYPE_WB;
  logic [17:0] E_BEQ, E_ADDI_EX, E_ANDI_EX, E_IMM_WB, E_JUMP, E_TRAP;

  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [17:0] e, input string tag);
    @(posedge clk);
    #1;
    rst_n     = rst;
    opcode    = op;
    mem_ready = rdy;
    sb.push_back('{tag, e});
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, w_obs, e.v);
      check({e.tag, "_rw_excl"}, {17'd0, mem_read & mem_write}, 18'd0);
    end
  end

  initial begin
    //               pcw pcc io mr mw irw m2r rd rw sa sb     ps     aop   done ill
    E_IDLE       = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    E_FETCH_W    = ov(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b11, 0, 0);
    E_FETCH_R    = ov(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b11, 0, 0);
    E_DECODE     = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b11, 0, 0);
    E_DECODE_NOP = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b11, 1, 0);
    E_MEMADR     = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b11, 0, 0);
    E_MEMRD      = ov(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    E_MEMWB      = ov(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    E_MEMWR_W    = ov(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    E_MEMWR_R    = ov(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    E_RTYPE_EX   = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0);
    E_RTYPE_WB   = ov(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    E_BEQ        = ov(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b10, 1, 0);
    E_ADDI_EX    = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b11, 0, 0);
    E_ANDI_EX    = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b01, 0, 0);
    E_IMM_WB     = ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    E_JUMP       = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 0);
    E_TRAP       = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);

    // Reset held; state is unknown until the first reset edge.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b0, E_IDLE, "rst_idle");
    step(1'b1, 6'd0, 1'b1, E_IDLE, "idle_exit");

    // R-type, zero wait: retire in cycle 4
    step(1'b1, 6'b000000, 1'b1, E_FETCH_R,  "r_fetch");
    step(1'b1, 6'b000000, 1'b1, E_DECODE,   "r_decode");
    step(1'b1, 6'b000000, 1'b1, E_RTYPE_EX, "r_ex");
    step(1'b1, 6'b000000, 1'b1, E_RTYPE_WB, "r_wb");

    // lw with two wait cycles in MEMRD: retire in cycle 7
    step(1'b1, 6'b100011, 1'b1, E_FETCH_R, "lw_fetch");
    step(1'b1, 6'b100011, 1'b1, E_DECODE,  "lw_decode");
    step(1'b1, 6'b100011, 1'b1, E_MEMADR,  "lw_memadr");
    step(1'b1, 6'b100011, 1'b0, E_MEMRD,   "lw_memrd0");
    step(1'b1, 6'b100011, 1'b0, E_MEMRD,   "lw_memrd1");
    step(1'b1, 6'b100011, 1'b1, E_MEMRD,   "lw_memrd2");
    step(1'b1, 6'b100011, 1'b1, E_MEMWB,   "lw_memwb");

    // beq with one fetch wait cycle
    step(1'b1, 6'b000100, 1'b0, E_FETCH_W, "beq_fetch_wait");
    step(1'b1, 6'b000100, 1'b1, E_FETCH_R, "beq_fetch");
    step(1'b1, 6'b000100, 1'b1, E_DECODE,  "beq_decode");
    step(1'b1, 6'b000100, 1'b1, E_BEQ,     "beq_ex");

    // j
    step(1'b1, 6'b000010, 1'b1, E_FETCH_R, "j_fetch");
    step(1'b1, 6'b000010, 1'b1, E_DECODE,  "j_decode");
    step(1'b1, 6'b000010, 1'b1, E_JUMP,    "j_jump");

    // andi then addi back-to-back
    step(1'b1, 6'b001100, 1'b1, E_FETCH_R, "andi_fetch");
    step(1'b1, 6'b001100, 1'b1, E_DECODE,  "andi_decode");
    step(1'b1, 6'b001100, 1'b1, E_ANDI_EX, "andi_ex");
    step(1'b1, 6'b001100, 1'b1, E_IMM_WB,  "andi_wb");
    step(1'b1, 6'b001000, 1'b1, E_FETCH_R, "addi_fetch");
    step(1'b1, 6'b001000, 1'b1, E_DECODE,  "addi_decode");
    step(1'b1, 6'b001000, 1'b1, E_ADDI_EX, "addi_ex");
    step(1'b1, 6'b001000, 1'b1, E_IMM_WB,  "addi_wb");

    // sw with one wait cycle: retire in cycle 5
    step(1'b1, 6'b101011, 1'b1, E_FETCH_R, "sw_fetch");
    step(1'b1, 6'b101011, 1'b1, E_DECODE,  "sw_decode");
    step(1'b1, 6'b101011, 1'b1, E_MEMADR,  "sw_memadr");
    step(1'b1, 6'b101011, 1'b0, E_MEMWR_W, "sw_memwr_wait");
    step(1'b1, 6'b101011, 1'b1, E_MEMWR_R, "sw_memwr_rdy");

    // Unknown opcode
    step(1'b1, 6'b111111, 1'b1, E_FETCH_R, "ill_fetch");
`ifdef CTRL_ILLEGAL_TRAP_EN
    step(1'b1, 6'b111111, 1'b1, E_DECODE, "ill_decode");
    for (int i = 0; i < 10; i++) step(1'b1, 6'b000000, 1'b1, E_TRAP, "ill_trap");
    step(1'b0, 6'b000000, 1'b1, E_TRAP, "ill_trap_rst");
    step(1'b1, 6'b000000, 1'b1, E_IDLE, "ill_after_rst");
`else
    step(1'b1, 6'b111111, 1'b1, E_DECODE_NOP, "ill_decode_nop");
`endif

    // Reset during a MEMWR wait abandons the store
    step(1'b1, 6'b101011, 1'b1, E_FETCH_R, "rsw_fetch");
    step(1'b1, 6'b101011, 1'b1, E_DECODE,  "rsw_decode");
    step(1'b1, 6'b101011, 1'b1, E_MEMADR,  "rsw_memadr");
    step(1'b1, 6'b101011, 1'b0, E_MEMWR_W, "rsw_memwr_wait");
    step(1'b0, 6'b101011, 1'b0, E_MEMWR_W, "rsw_rst_edge");
    step(1'b1, 6'b101011, 1'b0, E_IDLE,    "rsw_after_rst");
    step(1'b1, 6'b101011, 1'b0, E_FETCH_W, "rsw_refetch");

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
